// File: rtl/week_5_pkg.sv
// rtl/week_5_pkg.sv - shared state encoding and constants for the gate checker
// Purpose: FSM state type, vector count and counter widths used by all
// gate-checker files. No ports.
package week_5_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam int NUM_VECTORS = 4;
   localparam int SETTLE_W    = 4;   // holds SETTLE_CYCLES 0..15
   localparam int COUNT_W     = 3;   // holds 0..NUM_VECTORS

endpackage

// File: rtl/week_5_gate_checker_if.sv
// rtl/week_5_gate_checker_if.sv - request/result bundle between checker and its user
// Purpose: groups the run request, gate stimulus/response and scoreboard signals.
// Modports:
//   master : checker side (drives a/b and results, receives start and dut_y)
//   slave  : user side (drives start and dut_y, observes a/b and results)
interface week_5_gate_checker_if;
   import week_5_pkg::*;

   logic               start;
   logic               dut_y;
   logic               a;
   logic               b;
   logic               busy;
   logic               done;
   logic               pass;
   logic [COUNT_W-1:0] pass_count;
   logic [COUNT_W-1:0] fail_count;
   logic [NUM_VECTORS-1:0] fail_mask;

   modport master (
      input  start, dut_y,
      output a, b, busy, done, pass, pass_count, fail_count, fail_mask
   );

   modport slave (
      output start, dut_y,
      input  a, b, busy, done, pass, pass_count, fail_count, fail_mask
   );

endinterface

// File: rtl/week_5_settle_timer.sv
// rtl/week_5_settle_timer.sv - loadable down-counter timing the per-vector settle window
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : load counter with value (has priority over dec)
//   value    : load value
//   dec      : decrement by one, saturating at zero
//   zero     : counter currently holds zero
module week_5_settle_timer
   import week_5_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] value,
   input  logic                dec,
   output logic                zero
);

   logic [SETTLE_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/week_5_gate_checker.sv
// rtl/week_5_gate_checker.sv - on-chip exhaustive checker for a 2-input gate
// Parameters:
//   TRUTH_TABLE   : expected gate output, bit index = {a,b}
//   SETTLE_CYCLES : extra hold cycles per vector before sampling (0..15)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of week_5_gate_checker_if (start/dut_y in,
//              a/b, busy, done, pass, counts and fail_mask out)
module week_5_gate_checker
   import week_5_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
   parameter int         SETTLE_CYCLES = 2
)
(
   input logic                 clk,
   input logic                 rst,
   week_5_gate_checker_if.master bus
);

   // The timer is loaded one below SETTLE_CYCLES because the FSM leaves
   // SETTLE on the cycle it sees zero, giving exactly SETTLE_CYCLES cycles there.
   localparam int                  LOAD_INT    = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = LOAD_INT[SETTLE_W-1:0];

   state_t     state;
   state_t     state_n;
   logic [1:0] idx;
   logic       timer_zero;
   logic       vec_match;

   week_5_settle_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (state == APPLY),
      .value (SETTLE_LOAD),
      .dec   (state == SETTLE),
      .zero  (timer_zero)
   );

   // Case equality so an X/Z response never counts as a match.
   assign vec_match = (bus.dut_y === TRUTH_TABLE[idx]);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = APPLY;
         APPLY:   state_n = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
         SETTLE:  if (timer_zero) state_n = CHECK;
         CHECK:   state_n = (idx == 2'd3) ? DONE : APPLY;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs are registered from the current state, so they trail
   // the state register by one cycle (busy rises the edge after APPLY is entered).
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= 2'd0;
         bus.a          <= 1'b0;
         bus.b          <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.pass       <= 1'b0;
         bus.pass_count <= '0;
         bus.fail_count <= '0;
         bus.fail_mask  <= '0;
      end else begin
         state    <= state_n;
         bus.busy <= (state == APPLY) || (state == SETTLE) || (state == CHECK);
         bus.done <= (state == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  idx            <= 2'd0;
                  bus.pass       <= 1'b0;
                  bus.pass_count <= '0;
                  bus.fail_count <= '0;
                  bus.fail_mask  <= '0;
               end
            end
            APPLY: begin
               bus.a <= idx[1];
               bus.b <= idx[0];
            end
            CHECK: begin
               if (vec_match) begin
                  bus.pass_count <= bus.pass_count + 3'd1;
               end else begin
                  bus.fail_count     <= bus.fail_count + 3'd1;
                  bus.fail_mask[idx] <= 1'b1;
               end
               if (idx != 2'd3) idx <= idx + 2'd1;
            end
            DONE: begin
               bus.pass <= (bus.pass_count == 3'(NUM_VECTORS));
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_week_5_gate_checker.sv
// tb/tb_week_5_gate_checker.sv - directed-vector bench for week_5_gate_checker
module tb_week_5_gate_checker;
   import week_5_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   mode     = 0;   // default instance response: 0 NOR, 1 OR, 2 stuck 0, 3 X on vector 0
   int   trace [0:63];
   int   d;
   int   dones;

   always #5 clk = ~clk;

   week_5_gate_checker_if i0 ();
   week_5_gate_checker_if i1 ();

   logic y_nor, y_or, y_nand;
   nor  g_nor  (y_nor,  i0.a, i0.b);
   or   g_or   (y_or,   i0.a, i0.b);
   nand g_nand (y_nand, i1.a, i1.b);

   assign i0.dut_y = (mode == 1) ? y_or :
                     (mode == 2) ? 1'b0 :
                     ((mode == 3) && !(i0.a | i0.b)) ? 1'bx : y_nor;
   assign i1.dut_y = y_nand;

   week_5_gate_checker u_def (
      .clk (clk),
      .rst (rst),
      .bus (i0)
   );

   week_5_gate_checker #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(0)) u_s0 (
      .clk (clk),
      .rst (rst),
      .bus (i1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_a"},    32'(i0.a), 0);
      check({tag, "_b"},    32'(i0.b), 0);
      check({tag, "_busy"}, 32'(i0.busy), 0);
      check({tag, "_done"}, 32'(i0.done), 0);
      check({tag, "_pass"}, 32'(i0.pass), 0);
      check({tag, "_pc"},   32'(i0.pass_count), 0);
      check({tag, "_fc"},   32'(i0.fail_count), 0);
      check({tag, "_mask"}, 32'(i0.fail_mask), 0);
   endtask

   // Starts a run (start sampled at edge 0) and returns the edge index after
   // which done is first seen high, or -1 if it never comes within 40 edges.
   // restart_at > 0 re-pulses start so it is sampled at that edge.
   task automatic run_seq(input bit inst, input int restart_at, output int done_at);
      done_at = -1;
      @(negedge clk);
      if (inst) i1.start = 1'b1; else i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      i1.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == restart_at) begin
            if (inst) i1.start = 1'b1; else i0.start = 1'b1;
         end
         @(negedge clk);
         i0.start = 1'b0;
         i1.start = 1'b0;
         trace[c] = inst ? int'({i1.a, i1.b}) : int'({i0.a, i0.b});
         if (inst ? i1.done : i0.done) begin
            done_at = c;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int exp_pass, input int exp_pc,
                               input int exp_fc, input int exp_mask);
      check({tag, "_busy"}, 32'(i0.busy), 0);
      check({tag, "_pass"}, 32'(i0.pass), 32'(exp_pass));
      check({tag, "_pc"},   32'(i0.pass_count), 32'(exp_pc));
      check({tag, "_fc"},   32'(i0.fail_count), 32'(exp_fc));
      check({tag, "_mask"}, 32'(i0.fail_mask), 32'(exp_mask));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i0.start = 1'b0;
      i1.start = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      check("reset_s0_busy", 32'(i1.busy), 0);
      rst = 1'b0;

      // Correct NOR against default table
      mode = 0;
      run_seq(1'b0, 0, d);
      check("nor_done_at", 32'(d), 17);
      check_result("nor", 1, 4, 0, 4'b0000);
      @(negedge clk);
      check("nor_done_pulse", 32'(i0.done), 0);
      check("nor_ab_held", 32'({i0.a, i0.b}), 3);

      // OR gate where NOR is expected
      mode = 1;
      run_seq(1'b0, 0, d);
      check("or_done_at", 32'(d), 17);
      check_result("or", 0, 0, 4, 4'b1111);

      // Output stuck at 0
      mode = 2;
      run_seq(1'b0, 0, d);
      check_result("stuck", 0, 3, 1, 4'b0001);

      // Zero settle, NAND table, vector stepping every 2 cycles
      run_seq(1'b1, 0, d);
      check("s0_done_at", 32'(d), 9);
      check("s0_pass", 32'(i1.pass), 1);
      check("s0_pc", 32'(i1.pass_count), 4);
      check("s0_busy", 32'(i1.busy), 0);
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("s0_vec_e%0d", c), 32'(trace[c]), 32'((c - 1) / 2));
      end

      // Start pulse mid-run is ignored
      mode = 0;
      run_seq(1'b0, 5, d);
      check("restart_done_at", 32'(d), 17);
      check_result("restart", 1, 4, 0, 4'b0000);

      // X response on vector 0
      mode = 3;
      run_seq(1'b0, 0, d);
      check_result("xresp", 0, 3, 1, 4'b0001);

      // Reset during vector 2
      mode = 0;
      @(negedge clk);
      i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      repeat (10) @(negedge clk);
      check("prerst_vec", 32'({i0.a, i0.b}), 2);
      check("prerst_busy", 32'(i0.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle_zero("midrst");
      rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (i0.done) dones++;
      end
      check("midrst_no_done", 32'(dones), 0);
      run_seq(1'b0, 0, d);
      check("postrst_done_at", 32'(d), 17);
      check_result("postrst", 1, 4, 0, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/week_5_gate_checker.md
# week_5_gate_checker

Synthesizable self-checking stimulus stage for 2-input combinational gates. On `start` it drives the four input vectors `{a,b}` = 00, 01, 10, 11 into a gate under test, waits a programmable settle time, samples the gate output and compares it with a parameterized truth table. It sits directly upstream and downstream of the week 4 gates: its `a`/`b` feed the gate, and the gate's `y` returns on `dut_y`. It replaces per-gate hand-written stimulus with one reusable on-chip checker.

## Interface
- `TRUTH_TABLE`, default 4'b0001: expected output per vector; bit index = `{a,b}`. The default is NOR.
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling. Legal range 0..15.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run the sequence. Ignored unless the checker is idle.
- `dut_y`  in  1  output of the gate under test.
- `a`  out  1  gate input, MSB of the vector index.
- `b`  out  1  gate input, LSB of the vector index.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse when the sequence completes.
- `pass`  out  1  high when the last completed run had 4/4 matches. Held until the next `start`.
- `pass_count`  out  3  matches in the current or last run, 0..4.
- `fail_count`  out  3  mismatches in the current or last run, 0..4.
- `fail_mask`  out  4  bit i set when vector i mismatched.

## Operation
- **Reset state:** all outputs are 0 (`a=b=0`, `busy=done=pass=0`, counts and mask 0), and the FSM is in IDLE.
- **FSM states:** IDLE, APPLY, SETTLE, CHECK, DONE.
  - **IDLE:** on `start`, clear counts, mask and `pass`; set vector index to 0; go to APPLY.
  - **APPLY:** drive `{a,b}` = index and load the settle counter with `SETTLE_CYCLES`. Go to SETTLE, or directly to CHECK when `SETTLE_CYCLES` = 0.
  - **SETTLE:** decrement the counter. Go to CHECK when it reaches 0.
  - **CHECK:** sample `dut_y`.
    - Match only when `dut_y` equals `TRUTH_TABLE[index]` exactly. X or Z counts as a mismatch.
    - On a match, increment `pass_count`. On a mismatch, increment `fail_count` and set `fail_mask[index]`.
    - If index is 3, go to DONE; otherwise increment the index and go to APPLY.
  - **DONE:** pulse `done` for one cycle; `pass` = (`pass_count` = 4). Return to IDLE.
- **During a run:** `busy` is high in APPLY, SETTLE and CHECK; it is low in IDLE and DONE.
- **`start` while busy or in DONE:** ignored, with no side effects.
- **Reset mid-run:** abort immediately and return to reset values. No `done` pulse is produced.
- **After a run:** `a`/`b` keep the last vector (11) until the next `start` or reset.
- **Counter arithmetic:** the counters never exceed 4, and `pass_count + fail_count` = 4 at `done`.

## Timing
- Let N = `SETTLE_CYCLES` + 2, the number of cycles per vector (APPLY + SETTLE×S + CHECK).
- `start` is sampled at edge 0. `a`/`b` show vector 0 and `busy`=1 from edge 1.
- Vector k is driven from edge 1 + k·N.
- The output is sampled at the edge ending the CHECK cycle. The gate is therefore given `SETTLE_CYCLES` + 1 full cycles of stable inputs.
- `done` is high for the cycle after edge 1 + 4N. `busy` is low in the same cycle.
- Defaults (S=2, N=4): `done` appears 17 cycles after the `start` edge.
- With S=0: N=2 and `done` appears at edge 9.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `week_5_pkg` holds:
  - the state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - `NUM_VECTORS` = 4;
  - the settle counter width constant (4 bits).
- One sub-module is natural: `week_5_settle_timer`, a loadable down-counter with `load`, `value` and `zero` ports.
- The top level holds the FSM, vector index, scoreboard counters and mask.

## Test plan
- **NOR correct:** default parameters with a structural NOR on `dut_y`; `start` -> `done` 17 cycles later, `pass`=1, `pass_count`=4, `fail_count`=0, `fail_mask`=0000.
- **Wrong gate:** default parameters with an OR gate on `dut_y`; `start` -> `pass`=0, `fail_count`=4, `fail_mask`=1111.
- **Stuck output:** `TRUTH_TABLE`=4'b0001 with `dut_y` tied to 0; `start` -> `pass_count`=3, `fail_count`=1, `fail_mask`=0001.
- **Zero settle and vector sequence:** `SETTLE_CYCLES`=0 with a NAND on `dut_y` and `TRUTH_TABLE`=4'b0111; `start` -> `done` at cycle 9, `pass`=1, and `{a,b}` steps 00, 01, 10, 11 every 2 cycles.
- **Reset mid-run:** assert `rst` during vector 2 -> next cycle shows all outputs 0, `busy`=0 and no `done`; a subsequent `start` runs a full, correct sequence.
- **Start while busy:** pulse `start` again at cycle 5 of a run -> ignored; `done` still arrives at cycle 17 with unchanged counts. Also check X handling: `dut_y`=X on vector 0 -> `fail_mask[0]`=1.
